// File: rtl/game_flow_control_if.sv
// Signal bundle between the playfield/screen sources and the game sequencer.
// The bench or upstream logic drives through the master side; the sequencer
// sits on the slave side.
interface game_flow_control_if;
    logic        startOfFrame;
    logic        key5IsPressed;
    logic [3:0]  life;
    logic [15:0] score;
    logic [7:0]  RGB_screen_start;
    logic [7:0]  RGB_screen_main;
    logic [7:0]  RGB_screen_end;
    logic        start;
    logic [1:0]  screen_select;
    logic        game_won;
    logic [15:0] high_score;
    logic [7:0]  RGB_out;

    modport master (
        output startOfFrame, key5IsPressed, life, score,
               RGB_screen_start, RGB_screen_main, RGB_screen_end,
        input  start, screen_select, game_won, high_score, RGB_out
    );

    modport slave (
        input  startOfFrame, key5IsPressed, life, score,
               RGB_screen_start, RGB_screen_main, RGB_screen_end,
        output start, screen_select, game_won, high_score, RGB_out
    );
endinterface

// File: rtl/game_flow_control.sv
// Game sequencer: start screen -> playfield -> win/lose screen -> start screen.
// Arms new games with a one-cycle start pulse on key-5 release, picks which
// screen feeds the VGA pixel path and keeps the best final score since reset.
module game_flow_control #(
    parameter int          GAME_OVER_FRAMES = 180,
    parameter logic [15:0] WIN_SCORE        = 16'd1000
) (
    input  logic              clk,
    input  logic              reset,
    game_flow_control_if.slave gfc
);
    localparam int CNT_W = (GAME_OVER_FRAMES < 1) ? 1 : $clog2(GAME_OVER_FRAMES + 1);
    localparam logic [CNT_W-1:0] FRAME_MAX = CNT_W'(GAME_OVER_FRAMES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLAY     = 2'd1,
        END_WIN  = 2'd2,
        END_LOSE = 2'd3
    } state_t;

    function automatic logic [15:0] max_u16(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t            state_q;
    logic              key5_q;
    logic              armed_q;
    logic [CNT_W-1:0]  frame_cnt_q;
    logic [15:0]       high_score_q;
    logic [7:0]        rgb_q;

    logic              key_release;
    logic              win_hit;
    logic              lose_hit;
    logic [15:0]       high_score_d;
    logic [7:0]        rgb_d;

    // Act on key release only, so a key still held at game start cannot
    // launch anything in the new game.
    assign key_release  = key5_q & ~gfc.key5IsPressed;

    // Outcome checks are masked until the playfield has shown a live count,
    // since it may still present life=0 right after being started.
    assign win_hit      = armed_q && (gfc.score >= WIN_SCORE);
    assign lose_hit     = armed_q && (gfc.life == 4'd0);
    assign high_score_d = max_u16(high_score_q, gfc.score);

    // Pixel source follows the current state; registered below.
    always_comb begin
        rgb_d = gfc.RGB_screen_start;
        case (state_q)
            IDLE:    rgb_d = gfc.RGB_screen_start;
            PLAY:    rgb_d = gfc.RGB_screen_main;
            default: rgb_d = gfc.RGB_screen_end;
        endcase
    end

    // Sequencer state, arming, hold-off counter, high score and pixel register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            key5_q       <= 1'b0;
            armed_q      <= 1'b0;
            frame_cnt_q  <= '0;
            high_score_q <= 16'd0;
            rgb_q        <= 8'd0;
        end else begin
            key5_q <= gfc.key5IsPressed;
            rgb_q  <= rgb_d;
            case (state_q)
                IDLE: begin
                    if (key_release) begin
                        state_q <= PLAY;
                        armed_q <= 1'b0;
                    end
                end
                PLAY: begin
                    if (gfc.life != 4'd0) begin
                        armed_q <= 1'b1;
                    end
                    // A win takes precedence when both outcomes land together.
                    if (win_hit) begin
                        state_q      <= END_WIN;
                        frame_cnt_q  <= '0;
                        high_score_q <= high_score_d;
                    end else if (lose_hit) begin
                        state_q      <= END_LOSE;
                        frame_cnt_q  <= '0;
                        high_score_q <= high_score_d;
                    end
                end
                default: begin
                    if (gfc.startOfFrame && (frame_cnt_q != FRAME_MAX)) begin
                        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                    end
                    if (key_release && (frame_cnt_q == FRAME_MAX)) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    // Start pulse is a Mealy output on the IDLE release cycle; reset masks it.
    assign gfc.start         = ~reset & (state_q == IDLE) & key_release;
    assign gfc.screen_select = (state_q == IDLE) ? 2'd0 :
                               (state_q == PLAY) ? 2'd1 : 2'd2;
    assign gfc.game_won      = (state_q == END_WIN);
    assign gfc.high_score    = high_score_q;
    assign gfc.RGB_out       = rgb_q;
endmodule
